// File: rtl/hrv_pkg.sv
// Shared definitions for the HRV pipeline: default timing constants,
// the RR interval type handed between stages, and the front-end FSM states.
package hrv_pkg;

    localparam int unsigned RR_W       = 12;
    localparam int unsigned TICK_DIV   = 10000;
    localparam int unsigned REFRACT_MS = 250;
    localparam int unsigned TIMEOUT_MS = 3000;

    typedef logic [RR_W-1:0] rr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        MEASURE = 2'd2
    } rr_state_t;

endpackage

// File: rtl/beat_sync_edge.sv
// Brings the asynchronous beat pulse into the clk domain and emits a
// single-cycle rise strobe on each rising edge, independent of pulse width.
module beat_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic beat_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= beat_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/rr_interval_meter.sv
// HRV front end: measures the time between accepted heartbeat edges in
// milliseconds and delivers each interval on a valid/ready handshake.
// Beats inside the refractory window are ignored; a missing beat for
// TIMEOUT_MS ms drops the meter back to IDLE.
module rr_interval_meter #(
    parameter int unsigned TICK_DIV   = hrv_pkg::TICK_DIV,
    parameter int unsigned RR_W       = hrv_pkg::RR_W,
    parameter int unsigned REFRACT_MS = hrv_pkg::REFRACT_MS,
    parameter int unsigned TIMEOUT_MS = hrv_pkg::TIMEOUT_MS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            beat_in,
    output logic [RR_W-1:0] rr_data,
    output logic            rr_valid,
    input  logic            rr_ready,
    output logic            beat_seen,
    output logic            timeout,
    output logic            overrun
);

    import hrv_pkg::rr_state_t;
    import hrv_pkg::IDLE;
    import hrv_pkg::REFRACT;
    import hrv_pkg::MEASURE;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic            rise;
    logic [PW-1:0]   presc;
    logic            ms_tick;
    logic [RR_W-1:0] cnt;
    logic [RR_W-1:0] cnt_eff;
    rr_state_t       state;
    rr_state_t       state_n;
    logic            arm;
    logic            accept;
    logic            to_hit;

    beat_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .beat_in (beat_in),
        .rise    (rise)
    );

    // Millisecond tick on prescaler wrap; cnt_eff folds in a tick landing
    // this cycle so thresholds and captured intervals see the updated count.
    always_comb begin
        ms_tick = (presc == PW'(TICK_DIV - 1));
        cnt_eff = cnt + {{(RR_W-1){1'b0}}, ms_tick};
    end

    // Next-state and per-cycle event decode
    always_comb begin
        state_n = state;
        arm     = 1'b0;
        accept  = 1'b0;
        to_hit  = 1'b0;
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        arm     = 1'b1;
                        state_n = REFRACT;
                    end
                end
                REFRACT: begin
                    if (cnt_eff >= RR_W'(REFRACT_MS)) begin
                        state_n = MEASURE;
                    end
                end
                MEASURE: begin
                    // Timeout has priority over a simultaneous beat
                    if (cnt_eff >= RR_W'(TIMEOUT_MS)) begin
                        to_hit  = 1'b1;
                        state_n = IDLE;
                    end else if (rise) begin
                        accept  = 1'b1;
                        state_n = REFRACT;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Prescaler and ms counter; restart from zero on every accepted beat
    // and stay cleared whenever the meter is idle.
    always_ff @(posedge clk) begin
        if (rst || state_n == IDLE || arm || accept) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= ms_tick ? '0 : presc + 1'b1;
            cnt   <= cnt_eff;
        end
    end

    // Output register: interval handshake, status pulses and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_data   <= '0;
            rr_valid  <= 1'b0;
            beat_seen <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            beat_seen <= arm | accept;
            timeout   <= to_hit;
            if (accept) begin
                if (!rr_valid || rr_ready) begin
                    rr_data  <= cnt_eff;
                    rr_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rr_valid && rr_ready) begin
                rr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_interval_meter.sv
// Self-checking bench for rr_interval_meter: directed scenarios followed by
// randomized beat traffic, all compared every cycle against a timestamp-based
// reference model of accepted beats and intervals.
module tb_rr_interval_meter;

    import hrv_pkg::*;

    localparam int T_DIV   = 4;
    localparam int T_REF   = 3;
    localparam int T_TO    = 20;
    localparam int T_RRW   = 12;
    localparam int MAXC    = 16384;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic             beat_in = 1'b0;
    logic [T_RRW-1:0] rr_data;
    logic             rr_valid;
    logic             rr_ready = 1'b1;
    logic             beat_seen;
    logic             timeout;
    logic             overrun;

    rr_interval_meter #(
        .TICK_DIV   (T_DIV),
        .RR_W       (T_RRW),
        .REFRACT_MS (T_REF),
        .TIMEOUT_MS (T_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .beat_in   (beat_in),
        .rr_data   (rr_data),
        .rr_valid  (rr_valid),
        .rr_ready  (rr_ready),
        .beat_seen (beat_seen),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model: input sample history and time of last accepted beat
    bit samp [0:MAXC-1];
    bit m_armed = 1'b0;
    int m_last  = 0;
    bit m_valid = 1'b0;
    int m_data  = 0;
    bit m_over  = 1'b0;
    bit m_seen  = 1'b0;
    bit m_to    = 1'b0;

    // Observations for directed scenarios
    int obs_seen, obs_to, obs_xfer, obs_xfer_data, obs_vcyc;
    int seen_cyc, to_cyc;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic clr_obs();
        obs_seen = 0; obs_to = 0; obs_xfer = 0; obs_xfer_data = -1; obs_vcyc = 0;
        seen_cyc = -1; to_cyc = -1;
    endtask

    // One clock edge of the reference model, using the inputs just sampled
    task automatic model_step();
        bit rise, hs, new_iv;
        int d, iv;
        iv = 0;
        if (rst) begin
            samp[cycle] = 1'b0;
            if (cycle >= 1) samp[cycle-1] = 1'b0;
            if (cycle >= 2) samp[cycle-2] = 1'b0;
            m_armed = 0; m_valid = 0; m_data = 0; m_over = 0; m_seen = 0; m_to = 0;
        end else begin
            samp[cycle] = beat_in;
            rise   = (cycle >= 3) && samp[cycle-2] && !samp[cycle-3];
            hs     = m_valid && rr_ready;
            new_iv = 0;
            m_seen = 0;
            m_to   = 0;
            if (!en) begin
                m_armed = 0;
            end else if (!m_armed) begin
                if (rise) begin
                    m_armed = 1; m_last = cycle; m_seen = 1;
                end
            end else begin
                d = cycle - m_last;
                if (d >= T_TO * T_DIV) begin
                    m_to = 1; m_armed = 0;
                end else if (rise && d > T_REF * T_DIV) begin
                    new_iv = 1; iv = d / T_DIV; m_last = cycle; m_seen = 1;
                end
            end
            if (new_iv) begin
                if (!m_valid || rr_ready) begin
                    m_data = iv; m_valid = 1;
                end else begin
                    m_over = 1;
                end
            end else if (hs) begin
                m_valid = 0;
            end
        end
    endtask

    // Advance one clock: tally handshake, step model, compare at negedge
    task automatic cyc();
        if (rr_valid && rr_ready) begin
            obs_xfer++; obs_xfer_data = int'(rr_data);
        end
        @(posedge clk);
        model_step();
        cycle++;
        @(negedge clk);
        check("rr_valid",  rr_valid,  m_valid);
        check("rr_data",   rr_data,   m_data);
        check("beat_seen", beat_seen, m_seen);
        check("timeout",   timeout,   m_to);
        check("overrun",   overrun,   m_over);
        if (beat_seen) begin obs_seen++; seen_cyc = cycle; end
        if (timeout)   begin obs_to++;   to_cyc   = cycle; end
        if (rr_valid)  obs_vcyc++;
    endtask

    // Rising beat followed by gap-1 further cycles before the next one may start
    task automatic beat(input int gap);
        beat_in = 1'b1;
        cyc();
        cyc();
        beat_in = 1'b0;
        repeat (gap - 2) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        clr_obs();
    endtask

    int hold;

    initial begin
        clr_obs();

        // Reset with beat_in toggling
        rst = 1'b1; en = 1'b1; rr_ready = 1'b1;
        beat_in = 1'b1; cyc();
        beat_in = 1'b0; cyc();
        check("rst_valid",   rr_valid,  0);
        check("rst_data",    rr_data,   0);
        check("rst_seen",    beat_seen, 0);
        check("rst_timeout", timeout,   0);
        check("rst_overrun", overrun,   0);
        check("rst_state",   int'(dut.state), int'(IDLE));
        rst = 1'b0;
        repeat (5) cyc();
        clr_obs();

        // Basic interval: rises 40 cycles apart -> 10 ms
        beat(40); beat(12);
        check("basic_seen",  obs_seen, 2);
        check("basic_xfer",  obs_xfer, 1);
        check("basic_data",  obs_xfer_data, 10);
        check("basic_vcyc",  obs_vcyc, 1);
        check("basic_to",    obs_to, 0);

        // Refractory: middle rise 8 cycles after the first is ignored
        do_reset();
        beat(8); beat(32); beat(12);
        check("refr_seen", obs_seen, 2);
        check("refr_xfer", obs_xfer, 1);
        check("refr_data", obs_xfer_data, 10);

        // Timeout then re-arm
        do_reset();
        beat(100);
        check("to_count", obs_to, 1);
        check("to_delay", to_cyc - seen_cyc, 80);
        check("to_state", int'(dut.state), int'(IDLE));
        clr_obs();
        beat(24); beat(12);
        check("rearm_seen", obs_seen, 2);
        check("rearm_xfer", obs_xfer, 1);
        check("rearm_data", obs_xfer_data, 6);

        // Backpressure: second interval dropped, overrun sticky
        do_reset();
        rr_ready = 1'b0;
        beat(40); beat(40); beat(40);
        check("bp_valid",   rr_valid, 1);
        check("bp_data",    rr_data, 10);
        check("bp_overrun", overrun, 1);
        clr_obs();
        rr_ready = 1'b1;
        repeat (3) cyc();
        check("bp_xfer",      obs_xfer, 1);
        check("bp_xfer_data", obs_xfer_data, 10);
        check("bp_valid_end", rr_valid, 0);

        // en low between beats: next beat only arms
        do_reset();
        beat(20);
        en = 1'b0; cyc(); en = 1'b1;
        beat(40);
        check("en_seen", obs_seen, 2);
        check("en_xfer", obs_xfer, 0);
        check("en_valid", rr_valid, 0);
        // Reset while an interval is pending
        rr_ready = 1'b0;
        beat(12);
        check("pend_valid", rr_valid, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_drop_valid", rr_valid, 0);
        rr_ready = 1'b1;
        do_reset();

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            if (hold > 0) begin
                hold--;
            end else begin
                beat_in = ~beat_in;
                hold = beat_in ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 90));
            end
            rr_ready = ($urandom_range(0, 99) < 70);
            en       = ($urandom_range(0, 99) >= 2);
            rst      = ($urandom_range(0, 999) < 4);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_interval_meter.md
Name: rr_interval_meter

Overview:
- Front-end stage of the HRV top level. It turns the raw heartbeat pulse arriving on a dedicated input pin into a stream of RR intervals in milliseconds.
- Each interval is delivered on a valid/ready handshake to the downstream HRV statistics stage.
- Rejects beats inside a refractory window and flags loss of signal (timeout).

Parameters:
TICK_DIV, 10000, clk cycles per 1 ms tick (10 MHz clk)
RR_W, 12, width of rr_data in ms (max 4095)
REFRACT_MS, 250, minimum accepted interval in ms; earlier beats are ignored
TIMEOUT_MS, 3000, interval at which measurement aborts; must be < 2**RR_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  block enable; low forces IDLE
beat_in  in  1  raw asynchronous beat pulse, active high
rr_data  out  RR_W  interval in ms, stable while rr_valid
rr_valid  out  1  interval available
rr_ready  in  1  downstream accepts; transfer when rr_valid & rr_ready
beat_seen  out  1  one-cycle pulse per accepted beat (LED/debug)
timeout  out  1  one-cycle pulse when TIMEOUT_MS elapses without an accepted beat
overrun  out  1  sticky: an interval was dropped because rr_valid was still pending

Behaviour:
- Reset:
  - All outputs are 0; FSM goes to IDLE; prescaler, ms counter and synchronizer flops are cleared.
  - Reset mid-operation discards any pending rr_valid.
- Input conditioning:
  - 2-flop synchronizer, then rising-edge detect (rise = s2 & ~s3).
  - Beat edge detect occurs 2 cycles after beat_in is first sampled high. Only rising edges count; pulse width is irrelevant.
- Prescaler:
  - Counts 0..TICK_DIV-1; ms_tick fires on the wrap.
  - Cleared to 0 in the cycle an accepted beat is detected, so the first tick lands TICK_DIV cycles after detection.
- ms counter:
  - Increments on ms_tick.
  - Cleared on an accepted beat; if ms_tick coincides with the beat, the captured value includes that tick.
- FSM states: IDLE, REFRACT, MEASURE.
  - IDLE: on rise, go to REFRACT, clear prescaler and counter, pulse beat_seen. No interval is produced.
  - REFRACT: rise is ignored. When count reaches REFRACT_MS, go to MEASURE.
  - MEASURE, on rise: capture count (plus a coincident tick) as the interval, pulse beat_seen, clear counters, go to REFRACT.
  - MEASURE, when count reaches TIMEOUT_MS without a rise: pulse timeout, go to IDLE. A rise in the same cycle as the timeout loses; the timeout wins.
- Output register:
  - rr_data and rr_valid are registered. rr_valid asserts in the cycle after the accepted edge detect, i.e. 3 cycles after beat_in is first sampled high.
  - rr_valid holds until a handshake.
  - New interval while rr_valid & ~rr_ready: new value dropped, overrun set (sticky until rst).
  - New interval in the same cycle as a handshake: the new value is loaded and rr_valid stays high.
- en low:
  - Synchronous return to IDLE; counters are cleared.
  - A pending rr_valid is retained until handshaken.
  - The synchronizer keeps running.
- Width rule: the counter is RR_W bits and never wraps, because timeout fires first.

Decomposition:
- Package hrv_pkg holds:
  - rr_state_t enum {IDLE, REFRACT, MEASURE};
  - default constants RR_W, TICK_DIV, REFRACT_MS, TIMEOUT_MS;
  - typedef rr_t = logic [RR_W-1:0], shared with the downstream HRV stage.
- One sub-module: beat_sync_edge (2-flop synchronizer plus rising-edge detector; output rise).

Test Plan:
All scenarios use TICK_DIV=4, REFRACT_MS=3, TIMEOUT_MS=20, en=1.
- Reset: hold rst 2 cycles with beat_in toggling -> rr_valid, rr_data, beat_seen, timeout and overrun all 0; FSM in IDLE.
- Basic interval: beat_in rises at cycle 10 and cycle 50, rr_ready=1 -> beat_seen pulses twice, rr_data=10, rr_valid for 1 cycle at cycle 53, no timeout.
- Refractory: rises at cycles 10, 18 and 50 -> cycle-18 beat produces no beat_seen and no interval; single rr_data=10.
- Timeout/rearm:
  - Rise at cycle 10, then none -> timeout pulses once, 80 cycles after the beat was detected; FSM in IDLE.
  - Next rise gives beat_seen but no rr_valid.
  - Following rise 24 cycles later gives rr_data=6.
- Backpressure:
  - rr_ready=0, rises at cycles 10, 50 and 90 -> rr_data holds 10, second interval dropped, overrun=1.
  - Raise rr_ready -> one transfer of 10, after which rr_valid=0.
- Reset/enable mid-measure:
  - Drop en for 1 cycle between beats -> no interval from the next beat; it only arms.
  - Assert rst while rr_valid=1 -> rr_valid=0 the next cycle.
